cpu_state_dumper: RTL and testbench

Hardware post-run state extractor that sits directly downstream of `single_cycle_cpu`. It lets the CPU run for a fixed number of cycles after reset and then freezes it. It then walks the register file and the low data-memory words through debug read ports and emits one record per entry on a valid/ready stream. This replaces the simulation-only hierarchical dump with a synthesizable path that a UART or trace sink can consume.

---
 rtl/cpu_state_dumper.sv | 251 +++++++++++++++++++++++++
 tb/tb_cpu_state_dumper.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dumper.sv
`default_nettype none
// ============================================================================
// Module   : cpu_state_dumper
// Purpose  : Post-run state extractor placed downstream of single_cycle_cpu.
//            Lets the CPU run CYCLE_LIMIT cycles after reset, then freezes it
//            and streams every register-file entry followed by the low
//            data-memory words as {kind, index, data} records on a
//            valid/ready interface.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            cpu_halt              - registered freeze request to the CPU
//            rf_dbg_addr/data      - RF debug port (combinational read)
//            dmem_dbg_addr/data    - DMEM debug port (one-cycle sync read)
//            out_valid/ready       - record handshake
//            out_kind/index/data   - record: 0=RF, 1=DMEM, 2=checksum
//            done                  - all records accepted, sticky to reset
// Options  : DUMP_CHECKSUM_EN - when defined, one trailing checksum record
//            holding the XOR of every RF and DMEM payload is emitted.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_state_dumper #(
    parameter int REG_WIDTH       = 64,
    parameter int RF_DEPTH        = 32,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int DMEM_DUMP_WORDS = 9,
    parameter int CYCLE_LIMIT     = 45
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       cpu_halt,
    output logic [4:0]                 rf_dbg_addr,
    input  logic [REG_WIDTH-1:0]       rf_dbg_data,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_dbg_addr,
    input  logic [REG_WIDTH-1:0]       dmem_dbg_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [9:0]                 out_index,
    output logic [REG_WIDTH-1:0]       out_data,
    output logic                       done
);

    localparam int                         c_CNT_W    = (CYCLE_LIMIT > 1) ? $clog2(CYCLE_LIMIT) : 1;
    localparam logic [c_CNT_W-1:0]         c_CNT_LAST = c_CNT_W'(CYCLE_LIMIT - 1);
    localparam logic [4:0]                 c_RF_LAST  = 5'(RF_DEPTH - 1);
    localparam logic [DMEM_ADDR_WIDTH-1:0] c_MEM_LAST = DMEM_ADDR_WIDTH'(DMEM_DUMP_WORDS - 1);
    localparam logic [1:0]                 c_KIND_RF  = 2'd0;
    localparam logic [1:0]                 c_KIND_MEM = 2'd1;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [1:0]                 c_KIND_SUM = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_HALT = 3'd1,
        S_RF   = 3'd2,
        S_MEM  = 3'd3,
`ifdef DUMP_CHECKSUM_EN
        S_SUM  = 3'd4,
`endif
        S_LAST = 3'd5,   // final record loaded, waiting for its acceptance
        S_DONE = 3'd6
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_CNT_W-1:0]           r_cycle_cnt;
    logic [4:0]                   r_rf_idx;
    logic [DMEM_ADDR_WIDTH-1:0]   r_mem_idx;
    logic                         r_rd_ok;
    logic                         r_cpu_halt;
    logic                         r_out_valid;
    logic [1:0]                   r_out_kind;
    logic [9:0]                   r_out_index;
    logic [REG_WIDTH-1:0]         r_out_data;
    logic                         r_done;
`ifdef DUMP_CHECKSUM_EN
    logic [REG_WIDTH-1:0]         r_chk;
`endif

    logic                         w_slot_free;
    logic                         w_load;
    logic [1:0]                   w_load_kind;
    logic [9:0]                   w_load_index;
    logic [REG_WIDTH-1:0]         w_load_data;

    // ------------------------------------------------------------------
    // Next-state and record-load decode
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_free  = !r_out_valid || out_ready;
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_kind  = c_KIND_RF;
        w_load_index = '0;
        w_load_data  = '0;
        case (r_state)
            S_RUN: begin
                if (r_cycle_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                // Settle cycle so the CPU's final write lands before reading.
                w_state_nxt = S_RF;
            end
            S_RF: begin
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_kind  = c_KIND_RF;
                    w_load_index = 10'(r_rf_idx);
                    w_load_data  = rf_dbg_data;
                    if (r_rf_idx == c_RF_LAST) begin
                        w_state_nxt = S_MEM;
                    end
                end
            end
            S_MEM: begin
                // rd_ok guarantees the sync-read data belongs to mem_idx.
                if (r_rd_ok && w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_kind  = c_KIND_MEM;
                    w_load_index = 10'(r_mem_idx);
                    w_load_data  = dmem_dbg_data;
                    if (r_mem_idx == c_MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
                        w_state_nxt = S_SUM;
`else
                        w_state_nxt = S_LAST;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_SUM: begin
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_kind  = c_KIND_SUM;
                    w_load_index = '0;
                    w_load_data  = r_chk;
                    w_state_nxt  = S_LAST;
                end
            end
`endif
            S_LAST: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, read-ready flag, output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_rf_idx    <= '0;
            r_mem_idx   <= '0;
            r_rd_ok     <= 1'b0;
            r_cpu_halt  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_kind  <= '0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_chk       <= '0;
`endif
        end else begin
            // Derived from the next state so halt rises on the same edge
            // the FSM leaves RUN, without any combinational path to the CPU.
            r_cpu_halt <= (w_state_nxt != S_RUN);
            r_done     <= (w_state_nxt == S_DONE);

            if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + c_CNT_W'(1);
            end

            case (r_state)
                S_HALT: begin
                    r_rf_idx  <= '0;
                    r_mem_idx <= '0;
                    r_rd_ok   <= 1'b0;
                end
                S_RF: begin
                    if (w_load) begin
                        r_rf_idx <= r_rf_idx + 5'd1;
                    end
                end
                S_MEM: begin
                    if (w_load) begin
                        r_mem_idx <= r_mem_idx + DMEM_ADDR_WIDTH'(1);
                        r_rd_ok   <= 1'b0;
                    end else begin
                        r_rd_ok   <= 1'b1;
                    end
                end
                default: begin
                    r_rd_ok <= 1'b0;
                end
            endcase

            // Load wins over drain so accept-and-load sustains full rate.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_kind  <= w_load_kind;
                r_out_index <= w_load_index;
                r_out_data  <= w_load_data;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

`ifdef DUMP_CHECKSUM_EN
            if (r_state == S_HALT) begin
                r_chk <= '0;
            end else if (w_load && (w_load_kind != c_KIND_SUM)) begin
                r_chk <= r_chk ^ w_load_data;
            end
`endif
        end
    end

    assign cpu_halt      = r_cpu_halt;
    assign rf_dbg_addr   = r_rf_idx;
    assign dmem_dbg_addr = r_mem_idx;
    assign out_valid     = r_out_valid;
    assign out_kind      = r_out_kind;
    assign out_index     = r_out_index;
    assign out_data      = r_out_data;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_state_dumper
// Purpose  : Self-checking bench for cpu_state_dumper. Two instances share
//            the clock and reset: CYCLE_LIMIT=45 and CYCLE_LIMIT=1. A select
//            bit routes one of them to the checker. Expected records come
//            from the bench memory arrays; expected load times come from the
//            stated throughput (RF 1/cycle, DMEM 1 per 2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_state_dumper;

    localparam int c_RW  = 64;
    localparam int c_RFD = 32;
    localparam int c_AW  = 10;
    localparam int c_DW  = 9;
`ifdef DUMP_CHECKSUM_EN
    localparam int c_NREC = c_RFD + c_DW + 1;
`else
    localparam int c_NREC = c_RFD + c_DW;
`endif

    typedef struct packed {
        logic [1:0]      kind;
        logic [9:0]      index;
        logic [c_RW-1:0] data;
    } rec_t;

    typedef struct {
        bit sel;       // 0: CYCLE_LIMIT=45 instance, 1: CYCLE_LIMIT=1 instance
        bit stalls;    // pseudo-random back-pressure
        bit rnd;       // random memory contents
        int exp_halt;  // edge after reset release where cpu_halt is first high
        int exp_n;     // records expected
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    bit   sel = 1'b0;

    logic [c_RW-1:0] rf_arr [32];
    logic [c_RW-1:0] dmem_arr [16];

    logic            halt1, val1, done1, halt2, val2, done2;
    logic [4:0]      rfa1, rfa2;
    logic [c_AW-1:0] dma1, dma2;
    logic [c_RW-1:0] dmq1, dmq2, dat1, dat2;
    logic [1:0]      kind1, kind2;
    logic [9:0]      idx1, idx2;

    logic            o_halt, o_valid, o_done;
    logic [1:0]      o_kind;
    logic [9:0]      o_index;
    logic [c_RW-1:0] o_data;
    logic [4:0]      o_rfa;
    logic [c_AW-1:0] o_dma;

    always #5 clk = ~clk;

    // Sync-read DMEM models: data follows the address one edge late.
    always @(posedge clk) dmq1 <= (dma1 < 16) ? dmem_arr[dma1[3:0]] : '0;
    always @(posedge clk) dmq2 <= (dma2 < 16) ? dmem_arr[dma2[3:0]] : '0;

    cpu_state_dumper #(.REG_WIDTH(c_RW), .RF_DEPTH(c_RFD), .DMEM_ADDR_WIDTH(c_AW),
                       .DMEM_DUMP_WORDS(c_DW), .CYCLE_LIMIT(45)) u_dut1 (
        .clk(clk), .reset(rst), .cpu_halt(halt1),
        .rf_dbg_addr(rfa1), .rf_dbg_data(rf_arr[rfa1]),
        .dmem_dbg_addr(dma1), .dmem_dbg_data(dmq1),
        .out_valid(val1), .out_ready(ready), .out_kind(kind1),
        .out_index(idx1), .out_data(dat1), .done(done1)
    );

    cpu_state_dumper #(.REG_WIDTH(c_RW), .RF_DEPTH(c_RFD), .DMEM_ADDR_WIDTH(c_AW),
                       .DMEM_DUMP_WORDS(c_DW), .CYCLE_LIMIT(1)) u_dut2 (
        .clk(clk), .reset(rst), .cpu_halt(halt2),
        .rf_dbg_addr(rfa2), .rf_dbg_data(rf_arr[rfa2]),
        .dmem_dbg_addr(dma2), .dmem_dbg_data(dmq2),
        .out_valid(val2), .out_ready(ready), .out_kind(kind2),
        .out_index(idx2), .out_data(dat2), .done(done2)
    );

    assign o_halt  = sel ? halt2 : halt1;
    assign o_valid = sel ? val2  : val1;
    assign o_done  = sel ? done2 : done1;
    assign o_kind  = sel ? kind2 : kind1;
    assign o_index = sel ? idx2  : idx1;
    assign o_data  = sel ? dat2  : dat1;
    assign o_rfa   = sel ? rfa2  : rfa1;
    assign o_dma   = sel ? dma2  : dma1;

    int   n_chk = 0;
    int   n_bad = 0;
    rec_t exp_q[$];

    task automatic chk(input string nm, input logic [c_RW-1:0] act, input logic [c_RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: fill memories and list the records in emission order.
    task automatic build_model(input bit rnd);
        logic [c_RW-1:0] x;
        x = '0;
        for (int i = 0; i < 32; i++)
            rf_arr[i] = rnd ? {$urandom, $urandom} : 64'(i);
        for (int j = 0; j < 16; j++)
            dmem_arr[j] = rnd ? {$urandom, $urandom} : 64'(256 + j);
        exp_q.delete();
        for (int i = 0; i < c_RFD; i++) begin
            exp_q.push_back('{kind: 2'd0, index: 10'(i), data: rf_arr[i]});
            x ^= rf_arr[i];
        end
        for (int j = 0; j < c_DW; j++) begin
            exp_q.push_back('{kind: 2'd1, index: 10'(j), data: dmem_arr[j]});
            x ^= dmem_arr[j];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back('{kind: 2'd2, index: 10'd0, data: x});
`endif
    endtask

    // Edge (after reset release) on which record k is loaded with ready held
    // high: RF starts 2 edges after halt at 1/cycle; DMEM needs one extra
    // address-settle cycle then runs at 1 per 2 cycles.
    function automatic int exp_load_edge(input int lim, input int k);
        if (k < c_RFD)        return lim + 2 + k;
        if (k < c_RFD + c_DW) return lim + 3 + c_RFD + 2 * (k - c_RFD);
        return lim + 3 + c_RFD + 2 * (c_DW - 1) + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt",  64'(o_halt),  0);
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_done",  64'(o_done),  0);
        chk("rst_kind",  64'(o_kind),  0);
        chk("rst_index", 64'(o_index), 0);
        chk("rst_data",  o_data,       0);
        chk("rst_rfa",   64'(o_rfa),   0);
        chk("rst_dma",   64'(o_dma),   0);
        rst = 1'b0;
    endtask

    // Runs from reset release until the last record is accepted.
    task automatic collect(input bit stalls, input int exp_halt, input int exp_n, input int lim);
        int   e = 0, got = 0, loads = 0, halt_edge = -1, stall_left = 0;
        bit   pv = 1'b0, pr = 1'b0, fin = 1'b0, early_done = 1'b0;
        rec_t prec, cur;
        prec  = '0;
        ready = 1'b1;
        while (!fin && e < 3000) begin
            @(posedge clk);
            #1;
            e++;
            cur = '{kind: o_kind, index: o_index, data: o_data};
            if (o_halt && halt_edge < 0) halt_edge = e;
            if (pv && pr) begin
                if (got < exp_q.size()) begin
                    chk($sformatf("rec%0d_kind", got),  64'(prec.kind),  64'(exp_q[got].kind));
                    chk($sformatf("rec%0d_index", got), 64'(prec.index), 64'(exp_q[got].index));
                    chk($sformatf("rec%0d_data", got),  prec.data,       exp_q[got].data);
                end else begin
                    chk("rec_extra", 64'(got), 64'(exp_q.size()));
                end
                got++;
                if (got == exp_n) begin
                    chk("done_at_last", 64'(o_done),  1);
                    chk("valid_at_last", 64'(o_valid), 0);
                    fin = 1'b1;
                end
            end else if (pv && !pr) begin
                chk("stall_valid", 64'(o_valid), 1);
                chk("stall_payload_lo", cur.data, prec.data);
                chk("stall_kind_idx", 64'({cur.kind, cur.index}), 64'({prec.kind, prec.index}));
            end
            if (o_done && got < exp_n) early_done = 1'b1;
            if (o_valid && !(pv && !pr)) begin
                if (!stalls)
                    chk($sformatf("load_edge%0d", loads), 64'(e), 64'(exp_load_edge(lim, loads)));
                loads++;
            end
            if (stalls) begin
                if (stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    ready = 1'b0;
                    stall_left = $urandom_range(1, 7) - 1;
                end else begin
                    ready = 1'b1;
                end
            end
            pv = o_valid;
            pr = ready;
            prec = cur;
        end
        chk("rec_count", 64'(got), 64'(exp_n));
        chk("halt_edge", 64'(halt_edge), 64'(exp_halt));
        chk("done_early", 64'(early_done), 0);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", 64'(o_done), 1);
        chk("idle_valid",  64'(o_valid), 0);
        chk("idle_halt",   64'(o_halt), 1);
    endtask

    scen_t tbl[5];

    initial begin
        tbl[0] = '{sel: 1'b0, stalls: 1'b0, rnd: 1'b0, exp_halt: 45, exp_n: c_NREC};
        tbl[1] = '{sel: 1'b0, stalls: 1'b1, rnd: 1'b0, exp_halt: 45, exp_n: c_NREC};
        tbl[2] = '{sel: 1'b0, stalls: 1'b1, rnd: 1'b1, exp_halt: 45, exp_n: c_NREC};
        tbl[3] = '{sel: 1'b1, stalls: 1'b0, rnd: 1'b0, exp_halt: 1,  exp_n: c_NREC};
        tbl[4] = '{sel: 1'b1, stalls: 1'b1, rnd: 1'b1, exp_halt: 1,  exp_n: c_NREC};

        for (int s = 0; s < 5; s++) begin
            sel = tbl[s].sel;
            build_model(tbl[s].rnd);
            ready = 1'b1;
            do_reset();
            collect(tbl[s].stalls, tbl[s].exp_halt, tbl[s].exp_n, sel ? 1 : 45);
        end

        // Reset while DMEM record 4 is held pending, then a full restart.
        begin
            int  w = 0;
            bit  hit = 1'b0;
            sel = 1'b0;
            build_model(1'b0);
            ready = 1'b1;
            do_reset();
            while (!hit && w < 500) begin
                @(posedge clk);
                #1;
                w++;
                if (o_valid && o_kind == 2'd1 && o_index == 10'd4) hit = 1'b1;
            end
            chk("mid_reached_mem4", 64'(hit), 1);
            ready = 1'b0;
            @(posedge clk);
            #1;
            chk("mid_pending_valid", 64'(o_valid), 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("mid_rst_valid", 64'(o_valid), 0);
            chk("mid_rst_halt",  64'(o_halt),  0);
            chk("mid_rst_done",  64'(o_done),  0);
            rst = 1'b0;
            collect(1'b0, 45, c_NREC, 45);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
